// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input
// and the decoder-facing instruction handshake.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, instruction, inst_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, inst_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read, a 2-entry {pc, instruction}
// buffer toward the decoder, and redirect handling that drops in-flight data.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WAIT_DISCARD} state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_fifo_pc   [2];
  logic [31:0] r_fifo_inst [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_rsp;
  logic        w_push;
  logic        w_pop;
  logic        w_issue;
  logic [1:0]  w_count_next;
  logic [31:0] w_target;

  assign w_target     = bus.redirect_pc & ~32'h3;
  assign w_rsp        = bus.imem_rvalid && (r_state != S_IDLE);
  assign w_push       = bus.imem_rvalid && (r_state == S_WAIT) && !bus.redirect_valid;
  assign w_pop        = (r_count != 2'd0) && bus.inst_ready && !bus.redirect_valid;
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // A new read may only go out when its response is guaranteed a free slot.
  assign w_issue = !rst && !bus.redirect_valid &&
                   ((r_state == S_IDLE) || ((r_state == S_WAIT) && bus.imem_rvalid)) &&
                   (w_count_next < 2'd2);

  assign bus.imem_req    = w_issue;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.inst_valid  = (r_count != 2'd0);
  assign bus.instruction = bus.inst_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
  assign bus.inst_pc     = bus.inst_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;

  // NOTE: buffer storage is deliberately not reset; the head is masked to zero
  // while empty, so stale contents can never reach the decoder.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_req_pc;
      r_fifo_inst[r_wr_ptr] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= w_target;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      // A response landing with the redirect is dropped and closes the request.
      if (w_rsp) begin
        r_state <= S_IDLE;
      end else if (r_state == S_WAIT) begin
        r_state <= S_WAIT_DISCARD;
      end
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc   <= r_fetch_pc;
        r_state    <= S_WAIT;
      end else if (w_rsp) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule
